// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner and its key-code FIFO.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } scan_state_t;

   function automatic int key_width(input int rows, input int cols);
      return $clog2(rows * cols);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Key-code FIFO: the head is visible combinationally, and the last popped code is held while empty.
module key_fifo
   import keypad_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int CW = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    occ;
   logic [WIDTH-1:0] last_q;
   logic             do_rd;
   logic             do_wr;

   assign empty   = (occ == '0);
   assign full    = (occ == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   // A pop on the same edge frees the slot, so a write into a full FIFO still succeeds.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? last_q : mem[rd_ptr];
   assign count   = occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         last_q <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            last_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         occ <= occ + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with debounced press/release detection, a key-code FIFO and an interrupt pulse.
module keypad_scan_fifo
   import keypad_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 3,
   parameter int SCAN_DIV   = 22727,
   parameter int DEBOUNCE   = 3,
   parameter int FIFO_DEPTH = 8,
   parameter int INT_CYCLES = 3,
   localparam int KW = key_width(ROWS, COLS),
   localparam int CW = count_width(FIFO_DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [COLS-1:0] col_n,
   output logic [ROWS-1:0] row_n,
   input  logic            rd_en,
   output logic [KW-1:0]   data,
   output logic            empty,
   output logic [CW-1:0]   count,
   output logic            overflow,
   output logic            interrupt
);

   localparam int RW  = $clog2(ROWS);
   localparam int CLW = $clog2(COLS);
   localparam int PW  = $clog2(SCAN_DIV);
   localparam int DW  = $clog2(DEBOUNCE + 1);
   localparam int IW  = $clog2(INT_CYCLES + 1);

   logic [COLS-1:0] col_sync1;
   logic [COLS-1:0] col_sync2;
   logic [PW-1:0]   presc;
   logic            tick;
   scan_state_t     state;
   logic [RW-1:0]   row_idx;
   logic [RW-1:0]   row_next;
   logic [DW-1:0]   cnt;
   logic [CLW-1:0]  key_col;
   logic [KW-1:0]   key_code;
   logic            push_q;
   logic            attempt_q;
   logic [IW-1:0]   irq_left;
   logic            fifo_full;
   logic [COLS-1:0] col_active;
   logic            col_any;
   logic [CLW-1:0]  col_first;
   logic [KW-1:0]   new_code;
   logic            deb_done;

   assign tick = (presc == PW'(SCAN_DIV - 1));

   always_comb begin
      col_active = ~col_sync2;
      col_any    = |col_active;
      col_first  = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (col_active[i]) col_first = CLW'(i);
      end
      new_code = KW'(int'(row_idx) * COLS + int'(col_first));
      deb_done = (int'(cnt) + 1 >= DEBOUNCE);
      row_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_sync1 <= '1;
         col_sync2 <= '1;
         presc     <= '0;
      end else begin
         col_sync1 <= col_n;
         col_sync2 <= col_sync1;
         presc     <= tick ? '0 : presc + 1'b1;
      end
   end

   // Scanner FSM; an accept registers a push request and the attempt that starts the interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SCAN;
         row_idx   <= '0;
         row_n     <= ~ROWS'(1);
         cnt       <= '0;
         key_col   <= '0;
         key_code  <= '0;
         push_q    <= 1'b0;
         attempt_q <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         push_q    <= 1'b0;
         attempt_q <= 1'b0;
         if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (col_any) begin
                     key_col  <= col_first;
                     key_code <= new_code;
                     cnt      <= DW'(1);
                     if (DEBOUNCE == 1) begin
                        attempt_q <= 1'b1;
                        if (fifo_full) overflow <= 1'b1;
                        else           push_q   <= 1'b1;
                        state <= ST_HELD;
                     end else begin
                        state <= ST_DEBOUNCE;
                     end
                  end else begin
                     row_idx <= row_next;
                     row_n   <= ~(ROWS'(1) << row_next);
                  end
               end
               ST_DEBOUNCE: begin
                  if (col_any && col_first == key_col) begin
                     if (deb_done) begin
                        attempt_q <= 1'b1;
                        if (fifo_full) overflow <= 1'b1;
                        else           push_q   <= 1'b1;
                        state <= ST_HELD;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     cnt   <= '0;
                     state <= ST_SCAN;
                  end
               end
               ST_HELD: begin
                  if (!col_any) begin
                     cnt   <= DW'(1);
                     state <= (DEBOUNCE == 1) ? ST_SCAN : ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (col_any) begin
                     state <= ST_HELD;
                  end else if (deb_done) begin
                     cnt   <= '0;
                     state <= ST_SCAN;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

   // A fresh attempt reloads the timer, so overlapping accepts stretch the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_left  <= '0;
         interrupt <= 1'b0;
      end else if (attempt_q) begin
         irq_left  <= IW'(INT_CYCLES - 1);
         interrupt <= 1'b1;
      end else if (irq_left != '0) begin
         irq_left  <= irq_left - 1'b1;
         interrupt <= 1'b1;
      end else begin
         interrupt <= 1'b0;
      end
   end

   key_fifo #(
      .WIDTH(KW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (push_q),
      .wr_data(key_code),
      .rd_en  (rd_en),
      .rd_data(data),
      .empty  (empty),
      .full   (fifo_full),
      .count  (count)
   );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed and randomised key presses on a small keypad, checked against a queue model of accepted codes.
module tb_keypad_scan_fifo;
   import keypad_pkg::*;

   localparam int ROWS       = 4;
   localparam int COLS       = 3;
   localparam int SCAN_DIV   = 4;
   localparam int DEBOUNCE   = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int INT_CYCLES = 3;
   localparam int KW         = $clog2(ROWS * COLS);
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;
   // From the first tick on a newly driven row to the FIFO write: DEBOUNCE ticks plus one clk.
   localparam int ACCEPT_LAT = DEBOUNCE * SCAN_DIV + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [COLS-1:0] col_n;
   logic [ROWS-1:0] row_n;
   logic            rd_en;
   logic [KW-1:0]   data;
   logic            empty;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            interrupt;

   logic [ROWS-1:0][COLS-1:0] pressed;
   int  exp_q[$];
   bit  exp_ovf;
   int  exp_irq;
   int  irq_seen;
   int  irq_run;
   bit  irq_abort;
   logic irq_prev = 1'b0;
   int  last_pop;
   int  vectors;
   int  miscompares;

   keypad_scan_fifo #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
      .FIFO_DEPTH(FIFO_DEPTH), .INT_CYCLES(INT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n), .rd_en(rd_en),
      .data(data), .empty(empty), .count(count), .overflow(overflow), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   // Passive key matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_n = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int r, input int c, input bit down);
      pressed[r][c] = down;
   endtask

   always @(negedge rst_n) irq_abort = 1'b1;

   // Every interrupt pulse not cut short by reset must last exactly INT_CYCLES clocks.
   always @(negedge clk) begin
      if (interrupt === 1'b1 && irq_prev !== 1'b1) begin
         irq_seen++;
         irq_run   = 1;
         irq_abort = 1'b0;
      end else if (interrupt === 1'b1) begin
         irq_run++;
      end else if (irq_prev === 1'b1 && !irq_abort) begin
         checkOutput("irq_len", irq_run, INT_CYCLES);
      end
      irq_prev = interrupt;
   end

   task automatic checkReset(input string pfx);
      logic [ROWS-1:0] exp_row;
      exp_row = ~ROWS'(1);
      checkOutput({pfx, "_row_n"}, row_n, exp_row);
      checkOutput({pfx, "_empty"}, empty, 1);
      checkOutput({pfx, "_count"}, count, 0);
      checkOutput({pfx, "_data"}, data, 0);
      checkOutput({pfx, "_overflow"}, overflow, 0);
      checkOutput({pfx, "_interrupt"}, interrupt, 0);
   endtask

   // Returns on the first negedge after the scan newly drives row r.
   task automatic waitRow(input int r);
      logic [ROWS-1:0] prev;
      logic [ROWS-1:0] target;
      bit found;
      found  = 1'b0;
      target = ~(ROWS'(1) << r);
      prev   = row_n;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (row_n !== prev && row_n === target) found = 1'b1;
         prev = row_n;
      end
      checkOutput("row_wait", found, 1);
   endtask

   task automatic pressAccept(input int r, input int c, input bit pop_at_push, input int hold);
      logic [ROWS-1:0] exp_row;
      int code;
      code = r * COLS + c;
      waitRow(r);
      applyStimulus(r, c, 1'b1);
      repeat (ACCEPT_LAT - 1) @(negedge clk);
      if (pop_at_push) begin
         checkOutput("coinc_head", data, exp_q[0]);
         rd_en = 1'b1;
         void'(exp_q.pop_front());
      end
      @(negedge clk);
      rd_en = 1'b0;
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(code);
      else exp_ovf = 1'b1;
      exp_irq++;
      checkOutput("push_count", count, exp_q.size());
      checkOutput("push_irq", interrupt, 1);
      if (pop_at_push) checkOutput("coinc_data", data, exp_q[0]);
      repeat (hold - ACCEPT_LAT) @(negedge clk);
      applyStimulus(r, c, 1'b0);
      // DEBOUNCE inactive ticks return to SCAN; the row moves on the tick after that.
      repeat ((DEBOUNCE + 1) * SCAN_DIV - 1) @(negedge clk);
      exp_row = ~(ROWS'(1) << r);
      checkOutput("rel_row_hold", row_n, exp_row);
      @(negedge clk);
      exp_row = ~(ROWS'(1) << ((r + 1) % ROWS));
      checkOutput("rel_row_next", row_n, exp_row);
   endtask

   task automatic popCheck();
      int exp;
      exp = exp_q.pop_front();
      checkOutput("pop_data", data, exp);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      last_pop = exp;
      checkOutput("pop_count", count, exp_q.size());
   endtask

   initial begin
      int r, c, code;
      bit used [ROWS*COLS];
      logic [ROWS-1:0] exp_row;
      vectors = 0; miscompares = 0; exp_irq = 0; irq_seen = 0; irq_run = 0;
      exp_ovf = 1'b0; last_pop = 0;
      rst_n = 1'b0; rd_en = 1'b0; pressed = '0;
      repeat (3) @(negedge clk);
      checkReset("rst0");
      rst_n = 1'b1;

      // Directed key at row 2, column 1 -> code 7.
      pressAccept(2, 1, 1'b0, 4 * SCAN_DIV);
      checkOutput("k7_count", count, 1);
      checkOutput("k7_data", data, 7);
      checkOutput("k7_irq_pulses", irq_seen, exp_irq);

      // Column 0 bounces for two ticks only: no accept, scan carries on.
      waitRow(0);
      applyStimulus(0, 0, 1'b1);
      repeat (2 * SCAN_DIV) @(negedge clk);
      applyStimulus(0, 0, 1'b0);
      repeat (2 * SCAN_DIV) @(negedge clk);
      exp_row = ~(ROWS'(1) << 1);
      checkOutput("bounce_row", row_n, exp_row);
      checkOutput("bounce_count", count, exp_q.size());
      checkOutput("bounce_irq", irq_seen, exp_irq);

      popCheck();
      checkOutput("drain_empty", empty, 1);
      checkOutput("drain_hold", data, last_pop);

      // Five distinct random keys into a four-entry FIFO.
      for (int i = 0; i < ROWS * COLS; i++) used[i] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         do begin
            r = $urandom_range(ROWS - 1, 0);
            c = $urandom_range(COLS - 1, 0);
         end while (used[r * COLS + c]);
         used[r * COLS + c] = 1'b1;
         pressAccept(r, c, 1'b0, 4 * SCAN_DIV);
      end
      checkOutput("ovf_count", count, exp_q.size());
      checkOutput("ovf_flag", overflow, exp_ovf);
      checkOutput("ovf_irq", irq_seen, exp_irq);
      while (exp_q.size() > 0) popCheck();
      checkOutput("ovf_empty", empty, 1);
      checkOutput("ovf_hold", data, last_pop);
      checkOutput("ovf_sticky", overflow, exp_ovf);

      // Two entries, then a pop on the same edge as the third push.
      for (int k = 0; k < 3; k++) begin
         r = $urandom_range(ROWS - 1, 0);
         c = $urandom_range(COLS - 1, 0);
         pressAccept(r, c, k == 2, 4 * SCAN_DIV);
      end
      while (exp_q.size() > 0) popCheck();

      // A key held for 20 ticks is accepted once.
      r = $urandom_range(ROWS - 1, 0);
      c = $urandom_range(COLS - 1, 0);
      pressAccept(r, c, 1'b0, 20 * SCAN_DIV);
      repeat (4 * SCAN_DIV) @(negedge clk);
      checkOutput("held_count", count, exp_q.size());
      checkOutput("held_irq", irq_seen, exp_irq);
      popCheck();

      // Reset in the middle of a debounce.
      r = $urandom_range(ROWS - 1, 0);
      c = $urandom_range(COLS - 1, 0);
      waitRow(r);
      applyStimulus(r, c, 1'b1);
      repeat (SCAN_DIV + 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("rst_deb");
      applyStimulus(r, c, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); exp_ovf = 1'b0;
      repeat (10 * SCAN_DIV) @(negedge clk);
      checkOutput("rst_deb_count", count, 0);
      checkOutput("rst_deb_irq", irq_seen, exp_irq);

      // Reset in the middle of an interrupt pulse.
      waitRow(r);
      applyStimulus(r, c, 1'b1);
      repeat (ACCEPT_LAT + 1) @(negedge clk);
      exp_irq++;
      checkOutput("rst_irq_live", interrupt, 1);
      rst_n = 1'b0;
      #1;
      checkReset("rst_irq");
      applyStimulus(r, c, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); exp_ovf = 1'b0;
      repeat (10 * SCAN_DIV) @(negedge clk);
      checkOutput("rst_irq_count", count, 0);
      checkOutput("rst_irq_ovf", overflow, 0);
      checkOutput("rst_irq_pulses", irq_seen, exp_irq);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
